// File: rtl/hwpe_ctrl_package.sv
// Shared types for the sequential-multiplier feeder.
// The default operand/tag widths below feed the parameter defaults of
// hwpe_ctrl_seq_mult_feeder; the job/result structs describe the default-width
// view of what travels through the feeder.
package hwpe_ctrl_package;

  localparam int unsigned SEQ_MULT_AW = 8;
  localparam int unsigned SEQ_MULT_BW = 8;
  localparam int unsigned SEQ_MULT_TW = 4;

  typedef struct packed {
    logic [SEQ_MULT_AW-1:0] a;
    logic [SEQ_MULT_BW-1:0] b;
    logic                   invert;
    logic [SEQ_MULT_TW-1:0] tag;
  } seq_mult_job_t;

  typedef struct packed {
    logic [SEQ_MULT_AW+SEQ_MULT_BW-1:0] prod;
    logic [SEQ_MULT_TW-1:0]             tag;
  } seq_mult_res_t;

  // Feeder control states: idle, multiplier computing, result on offer.
  typedef enum logic [1:0] {
    FEED_IDLE = 2'd0,
    FEED_WAIT = 2'd1,
    FEED_DONE = 2'd2
  } seq_mult_feeder_state_e;

endpackage

// File: rtl/hwpe_ctrl_seq_mult_feeder_fifo.sv
// Generic DEPTH-entry register FIFO with synchronous clear.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// A push while full or a pop while empty is ignored.
module hwpe_ctrl_seq_mult_feeder_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hwpe_ctrl_seq_mult_feeder.sv
// Job feeder for the sequential unsigned multiplier.
// Jobs {a, b, invert, tag} are queued in a small FIFO, issued one at a time
// with operands held in a local register, and the product is returned with
// its tag on a valid/ready result stream, strictly in job order.
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never waits for ready, and a raised valid holds its
// data stable until the transfer.
// Optional build macro HWPE_CTRL_SEQ_MULT_FEEDER_STATS_EN adds saturating
// 16-bit job and busy-cycle counters.
module hwpe_ctrl_seq_mult_feeder
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned AW    = SEQ_MULT_AW,
  parameter int unsigned BW    = SEQ_MULT_BW,
  parameter int unsigned TW    = SEQ_MULT_TW,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic [AW-1:0]    job_a_i,
  input  logic [BW-1:0]    job_b_i,
  input  logic             job_invert_i,
  input  logic [TW-1:0]    job_tag_i,
  output logic             mult_start_o,
  output logic [AW-1:0]    mult_a_o,
  output logic [BW-1:0]    mult_b_o,
  output logic             mult_invert_o,
  input  logic             mult_valid_i,
  input  logic             mult_ready_i,
  input  logic [AW+BW-1:0] mult_prod_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [AW+BW-1:0] res_prod_o,
  output logic [TW-1:0]    res_tag_o
`ifdef HWPE_CTRL_SEQ_MULT_FEEDER_STATS_EN
  ,
  output logic [15:0]      stat_jobs_o,
  output logic [15:0]      stat_busy_o
`endif
);

  // Parameter-width view of a queued job.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          invert;
    logic [TW-1:0] tag;
  } job_t;

  localparam int unsigned JW = $bits(job_t);

  seq_mult_feeder_state_e state_q, state_d;

  job_t             job_in;
  job_t             job_head;
  job_t             op_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue;
  logic             capture;
  logic             accept;
  logic             start_q;
  logic [AW+BW-1:0] prod_q;
  logic [TW-1:0]    tag_q;

  assign job_in = {job_a_i, job_b_i, job_invert_i, job_tag_i};

  hwpe_ctrl_seq_mult_feeder_fifo #(
    .W     (JW),
    .DEPTH (DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (job_valid_i),
    .data_i  (job_in),
    .pop_i   (issue),
    .data_o  (job_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FEED_IDLE;
    else         state_q <= state_d;
  end

  // Next state and per-cycle strobes. start_q is high only in the first WAIT
  // cycle, so using it to mask valid ignores a valid left high by the
  // previous job. clear_i overrides every transition and strobe.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (!fifo_empty && mult_ready_i) begin
          issue   = 1'b1;
          state_d = FEED_WAIT;
        end
      end
      FEED_WAIT: begin
        if (!start_q && mult_valid_i) begin
          capture = 1'b1;
          state_d = FEED_DONE;
        end
      end
      FEED_DONE: begin
        if (res_ready_i) begin
          accept  = 1'b1;
          state_d = FEED_IDLE;
        end
      end
      default: state_d = FEED_IDLE;
    endcase
    if (clear_i) begin
      state_d = FEED_IDLE;
      issue   = 1'b0;
      capture = 1'b0;
      accept  = 1'b0;
    end
  end

  // Operand register, start strobe and result capture; all zeroed by clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= '0;
      start_q <= 1'b0;
      prod_q  <= '0;
      tag_q   <= '0;
    end else if (clear_i) begin
      op_q    <= '0;
      start_q <= 1'b0;
      prod_q  <= '0;
      tag_q   <= '0;
    end else begin
      start_q <= issue;
      if (issue) op_q <= job_head;
      if (capture) begin
        prod_q <= mult_prod_i;
        tag_q  <= op_q.tag;
      end
    end
  end

  assign job_ready_o   = !fifo_full;
  assign mult_start_o  = start_q;
  assign mult_a_o      = op_q.a;
  assign mult_b_o      = op_q.b;
  assign mult_invert_o = op_q.invert;
  assign res_valid_o   = (state_q == FEED_DONE);
  assign res_prod_o    = prod_q;
  assign res_tag_o     = tag_q;

`ifdef HWPE_CTRL_SEQ_MULT_FEEDER_STATS_EN
  logic [15:0] stat_jobs_q;
  logic [15:0] stat_busy_q;

  // Saturating counters: completed result handshakes and non-idle cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_jobs_q <= '0;
      stat_busy_q <= '0;
    end else if (clear_i) begin
      stat_jobs_q <= '0;
      stat_busy_q <= '0;
    end else begin
      if (accept && (stat_jobs_q != 16'hFFFF))
        stat_jobs_q <= stat_jobs_q + 16'd1;
      if ((state_q != FEED_IDLE) && (stat_busy_q != 16'hFFFF))
        stat_busy_q <= stat_busy_q + 16'd1;
    end
  end

  assign stat_jobs_o = stat_jobs_q;
  assign stat_busy_o = stat_busy_q;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_seq_mult_feeder.sv
// Bench for hwpe_ctrl_seq_mult_feeder: a behavioural sequential multiplier,
// job driver, result scoreboard fed from pushed jobs, directed scenarios and
// a randomized run. Build with HWPE_CTRL_SEQ_MULT_FEEDER_STATS_EN to also
// exercise the statistics counters.
module tb_hwpe_ctrl_seq_mult_feeder;

  localparam int unsigned AW    = 8;
  localparam int unsigned BW    = 8;
  localparam int unsigned TW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned PW    = AW + BW;

  localparam int R_RANDOM = 0;
  localparam int R_ALWAYS = 1;
  localparam int R_HOLD   = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [AW-1:0] job_a = '0;
  logic [BW-1:0] job_b = '0;
  logic          job_inv = 1'b0;
  logic [TW-1:0] job_tag = '0;
  logic          mult_start;
  logic [AW-1:0] mult_a;
  logic [BW-1:0] mult_b;
  logic          mult_inv;
  logic          mult_valid;
  logic          mult_ready;
  logic [PW-1:0] mult_prod;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [PW-1:0] res_prod;
  logic [TW-1:0] res_tag;
`ifdef HWPE_CTRL_SEQ_MULT_FEEDER_STATS_EN
  logic [15:0]   stat_jobs;
  logic [15:0]   stat_busy;
`endif

  hwpe_ctrl_seq_mult_feeder #(
    .AW(AW), .BW(BW), .TW(TW), .DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .job_valid_i   (job_valid),
    .job_ready_o   (job_ready),
    .job_a_i       (job_a),
    .job_b_i       (job_b),
    .job_invert_i  (job_inv),
    .job_tag_i     (job_tag),
    .mult_start_o  (mult_start),
    .mult_a_o      (mult_a),
    .mult_b_o      (mult_b),
    .mult_invert_o (mult_inv),
    .mult_valid_i  (mult_valid),
    .mult_ready_i  (mult_ready),
    .mult_prod_i   (mult_prod),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_prod_o    (res_prod),
    .res_tag_o     (res_tag)
`ifdef HWPE_CTRL_SEQ_MULT_FEEDER_STATS_EN
    ,
    .stat_jobs_o   (stat_jobs),
    .stat_busy_o   (stat_busy)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [PW+TW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Expected product from the arithmetic rule: a*b, negated mod 2^PW on invert.
  function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                             input logic inv);
    logic [31:0] p;
    p = a * b;
    if (inv) p = -p;
    return p[PW-1:0];
  endfunction

  // ---------------- behavioural multiplier ----------------
  // Counts only after a start; valid rises AW-1 (or AW with invert) cycles
  // after the start cycle and stays high until the next start is sampled.
  logic          m_busy, m_valid, m_inv;
  int            m_cnt;
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_b;
  logic [PW-1:0] m_prod;

  assign mult_valid = m_valid;
  assign mult_ready = !m_busy;
  assign mult_prod  = m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
      m_a <= '0; m_b <= '0; m_inv <= 1'b0; m_prod <= '0;
    end else if (clear) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end else if (mult_start) begin
      m_busy <= 1'b1; m_valid <= 1'b0;
      m_a <= mult_a; m_b <= mult_b; m_inv <= mult_inv;
      m_cnt <= int'(AW) - 3 + (mult_inv ? 1 : 0);
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_prod  <= m_inv ? (PW'(0) - PW'(m_a) * PW'(m_b)) : PW'(m_a) * PW'(m_b);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- monitor / result consumer ----------------
  int            rdy_mode = R_ALWAYS;
  int            cyc = 0;
  int            rise_cyc = -10;
  int            start_cnt = 0;
  int            rvalid_cnt = 0;
  logic          prev_mvalid = 1'b0, prev_rvalid = 1'b0, prev_start = 1'b0, prev_held = 1'b0;
  logic [PW-1:0] held_prod = '0;
  logic [TW-1:0] held_tag = '0;
`ifdef HWPE_CTRL_SEQ_MULT_FEEDER_STATS_EN
  int            sb_busy = 0;
  logic          inflight = 1'b0;
`endif

  always @(negedge clk) begin
    logic [PW+TW-1:0] e;
    cyc++;
    if (rst_n) begin
      if (mult_valid && !prev_mvalid) rise_cyc = cyc;
      if (res_valid && !prev_rvalid) chk("res_latency", 64'(cyc), 64'(rise_cyc + 1));
      if (prev_held) chk("res_hold", {res_valid, res_prod, res_tag}, {1'b1, held_prod, held_tag});
      if (mult_start) begin
        start_cnt++;
        chk("start_legal", {prev_start, m_busy}, 2'b00);
      end
      if (m_busy) chk("operands_stable", {mult_a, mult_b, mult_inv}, {m_a, m_b, m_inv});
      if (res_valid) rvalid_cnt++;
      case (rdy_mode)
        R_RANDOM: res_ready = ($urandom_range(0, 2) != 0);
        R_ALWAYS: res_ready = 1'b1;
        default:  res_ready = 1'b0;
      endcase
      prev_held = res_valid && !res_ready && !clear;
      held_prod = res_prod;
      held_tag  = res_tag;
      if (res_valid && res_ready && !clear) begin
        if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("res_prod", res_prod, e[PW+TW-1:TW]);
          chk("res_tag", res_tag, e[TW-1:0]);
        end
      end
`ifdef HWPE_CTRL_SEQ_MULT_FEEDER_STATS_EN
      if (clear) begin
        sb_busy  = 0;
        inflight = 1'b0;
      end else begin
        if (mult_start) inflight = 1'b1;
        if (inflight) sb_busy++;
        if (res_valid && res_ready) inflight = 1'b0;
      end
`endif
      prev_mvalid = mult_valid;
      prev_rvalid = res_valid;
      prev_start  = mult_start;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge following the push edge.
  task automatic push_job(input logic [AW-1:0] a, input logic [BW-1:0] b,
                          input logic inv, input logic [TW-1:0] tag);
    int n = 0;
    job_a = a; job_b = b; job_inv = inv; job_tag = tag; job_valid = 1'b1;
    while (!job_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) chk("push_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk);
      exp_q.push_back({ref_prod(a, b, inv), tag});
      @(negedge clk);
    end
    job_valid = 1'b0;
  endtask

  task automatic set_mode(input int m);
    @(posedge clk);
    #1 rdy_mode = m;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_single(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic inv,
                            input logic [TW-1:0] tag, input logic [PW-1:0] exp_prod);
    int s0;
    int lat = 0;
    s0 = start_cnt;
    push_job(a, b, inv, tag);
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("single_latency", 64'(lat), 64'(AW + 1 + (inv ? 1 : 0)));
    chk("single_prod", res_prod, exp_prod);
    chk("single_tag", res_tag, tag);
    repeat (3) @(negedge clk);
    chk("single_start_count", 64'(start_cnt - s0), 64'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, s0, r0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {job_ready, mult_start, mult_a, mult_b, mult_inv, res_valid, res_prod, res_tag},
        {1'b1, 39'd0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", {job_ready, mult_start, mult_a, mult_b, mult_inv, res_valid, res_prod, res_tag},
        {1'b1, 39'd0});

    // Single jobs: plain and inverted products with exact latency.
    run_single(8'd13, 8'd11, 1'b0, 4'd3, 16'd143);
    run_single(8'd3, 8'd5, 1'b1, 4'd9, 16'hFFF1);

    // Back-to-back pushes fill the FIFO while the first job computes.
    push_job(8'd7, 8'd9, 1'b0, 4'd1);
    push_job(8'd200, 8'd255, 1'b1, 4'd2);
    push_job(8'd1, 8'd0, 1'b0, 4'd5);
    chk("fifo_full_ready", job_ready, 1'b0);
    wait_drain();

    // Result held off for 20 cycles: stable data, no new start, prompt restart.
    set_mode(R_HOLD);
    push_job(8'd21, 8'd4, 1'b0, 4'd6);
    push_job(8'd9, 8'd9, 1'b1, 4'd7);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", res_valid, 1'b1);
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    chk("hold_no_start", 64'(start_cnt - s0), 64'd0);
    chk("hold_valid_level", res_valid, 1'b1);
    @(posedge clk);
    #1 rdy_mode = R_ALWAYS;
    @(negedge clk);
    @(negedge clk);
    chk("restart_gap_idle", mult_start, 1'b0);
    @(negedge clk);
    chk("restart_start", mult_start, 1'b1);
    wait_drain();

    // Clear while a job computes and two more are queued.
    push_job(8'd50, 8'd60, 1'b0, 4'd1);
    push_job(8'd70, 8'd80, 1'b0, 4'd2);
    push_job(8'd90, 8'd100, 1'b1, 4'd3);
    @(posedge clk);
    #1 clear = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("clear_state", {job_ready, mult_start, mult_a, mult_b, mult_inv, res_valid, res_prod, res_tag},
        {1'b1, 39'd0});
    r0 = rvalid_cnt;
    s0 = start_cnt;
    repeat (30) @(negedge clk);
    chk("clear_no_result", 64'(rvalid_cnt - r0), 64'd0);
    chk("clear_no_start", 64'(start_cnt - s0), 64'd0);

    // Randomized jobs with random consumer back-pressure.
    set_mode(R_RANDOM);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_job(AW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)), TW'($urandom));
    end
    wait_drain();

`ifdef HWPE_CTRL_SEQ_MULT_FEEDER_STATS_EN
    // Counters restart from a clear and track four jobs.
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      push_job(AW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)), TW'(i));
    wait_drain();
    repeat (5) @(negedge clk);
    chk("stat_jobs", stat_jobs, 16'd4);
    chk("stat_busy", stat_busy, 16'(sb_busy));
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
